// File: rtl/request_unit_if.sv
// Handshake bundle between the control unit / memory side and the request sequencer.
interface request_unit_if;
  logic        dren_req;
  logic        dwen_req;
  logic        mem_halt;
  logic        ihit;
  logic        dhit;
  logic        iREN;
  logic        dREN;
  logic        dWEN;
  logic        pc_en;
  logic        halt;
  logic        err;
  logic [31:0] retired;

  modport master (
    output dren_req, dwen_req, mem_halt, ihit, dhit,
    input  iREN, dREN, dWEN, pc_en, halt, err, retired
  );

  modport slave (
    input  dren_req, dwen_req, mem_halt, ihit, dhit,
    output iREN, dREN, dWEN, pc_en, halt, err, retired
  );
endinterface

// File: rtl/request_unit.sv
// Memory request sequencer: FETCH -> (DATA) -> FETCH, sticky HALT, retire counter.
// Optional DATA-wait timeout built when REQUNIT_TIMEOUT_EN is defined.
//
// state | meaning
// FETCH | iREN high, waiting on ihit; ALU ops retire here
// DATA  | dREN or dWEN held until dhit (or timeout)
// HALT  | all enables low, halt high; only RST leaves
module request_unit #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic CLK,
  input  logic RST,
  request_unit_if.slave bus
);

  typedef enum logic [1:0] {FETCH = 2'd0, DATA = 2'd1, HALT = 2'd2} state_t;

  state_t      state, state_nx;
  logic        iren_q, dren_q, dwen_q, halt_q, err_q;
  logic        dren_d, dwen_d;
  logic        pc_en_c;
  logic        to_fire;
  logic [31:0] retired_q;

  if (TIMEOUT >= (1 << TO_W) || TIMEOUT < 1) begin : g_bad_timeout
    $error("request_unit: TIMEOUT must be in 1 .. 2**TO_W-1");
  end

`ifdef REQUNIT_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  logic [TO_W-1:0] to_cnt;

  // Count value during DATA cycle k is k-1, so the TIMEOUT-th dhit-less cycle fires.
  assign to_fire = (state == DATA) && !bus.dhit && (to_cnt == TO_LAST);

  always_ff @(posedge CLK) begin
    if (RST) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state != DATA)  to_cnt <= '0;
      else if (!bus.dhit) to_cnt <= to_cnt + 1'b1;
      if (to_fire) err_q <= 1'b1;
    end
  end
`else
  assign to_fire = 1'b0;
  assign err_q   = 1'b0;
`endif

  always_ff @(posedge CLK) begin : state_reg
    if (RST) state <= FETCH;
    else     state <= state_nx;
  end

  always_comb begin : next_state
    state_nx = state;
    unique case (state)
      FETCH: begin
        if (bus.ihit) begin
          if (bus.mem_halt)                     state_nx = HALT;
          else if (bus.dwen_req || bus.dren_req) state_nx = DATA;
        end
      end
      DATA: begin
        if (bus.dhit)     state_nx = FETCH;
        else if (to_fire) state_nx = HALT;
      end
      HALT:    state_nx = HALT;
      default: state_nx = FETCH;
    endcase
  end

  always_comb begin : out_logic
    pc_en_c = 1'b0;
    dren_d  = 1'b0;
    dwen_d  = 1'b0;
    unique case (state)
      FETCH: begin
        pc_en_c = bus.ihit && !bus.mem_halt && !bus.dren_req && !bus.dwen_req;
        // Write wins when the control unit flags both.
        if (bus.ihit && !bus.mem_halt) begin
          dwen_d = bus.dwen_req;
          dren_d = bus.dren_req && !bus.dwen_req;
        end
      end
      DATA: begin
        pc_en_c = bus.dhit;
        if (!bus.dhit && !to_fire) begin
          dren_d = dren_q;
          dwen_d = dwen_q;
        end
      end
      default: begin
        pc_en_c = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin : out_reg
    if (RST) begin
      iren_q    <= 1'b1;
      dren_q    <= 1'b0;
      dwen_q    <= 1'b0;
      halt_q    <= 1'b0;
      retired_q <= '0;
    end else begin
      iren_q    <= (state_nx == FETCH);
      dren_q    <= dren_d;
      dwen_q    <= dwen_d;
      halt_q    <= halt_q || (state_nx == HALT);
      retired_q <= retired_q + {31'd0, pc_en_c};
    end
  end

  assign bus.iREN    = iren_q;
  assign bus.dREN    = dren_q;
  assign bus.dWEN    = dwen_q;
  assign bus.pc_en   = pc_en_c;
  assign bus.halt    = halt_q;
  assign bus.err     = err_q;
  assign bus.retired = retired_q;

endmodule

// File: tb/tb_request_unit.sv
// Self-checking bench for request_unit; retire counts are scoreboarded through exp_q.
// Timeout scenarios are exercised when REQUNIT_TIMEOUT_EN is defined.
module tb_request_unit;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int unsigned model_ret;
  int unsigned exp_q[$];

  request_unit_if bus();

  request_unit #(.TIMEOUT(5), .TO_W(8)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic clear_inputs();
    bus.ihit = 1'b0; bus.dhit = 1'b0;
    bus.dren_req = 1'b0; bus.dwen_req = 1'b0; bus.mem_halt = 1'b0;
  endtask

  task automatic pop_retired(input string name);
    int unsigned exp;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL %s: got retired=%0d want queued entry (queue empty)", name, bus.retired);
    end else begin
      exp = exp_q.pop_front();
      if (bus.retired !== exp) begin
        n_errors++;
        $display("FAIL %s: got retired=%0d want %0d", name, bus.retired, exp);
      end
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.iREN, bus.dREN, bus.dWEN, bus.halt, bus.err, bus.pc_en} !== 6'b100000 || bus.retired !== 32'd0) begin
      n_errors++;
      $display("FAIL reset: got ien/drn/dwn/hlt/err/pc=%b retired=%0d want 100000 retired=0",
               {bus.iREN, bus.dREN, bus.dWEN, bus.halt, bus.err, bus.pc_en}, bus.retired);
    end
    rst = 1'b0;
    model_ret = 0;
    exp_q.delete();
  endtask

  task automatic test_fetch_wait();
    for (int k = 0; k < 3; k++) begin
      bus.dhit = (k == 1);
      #1;
      n_checks++;
      if (bus.pc_en !== 1'b0 || bus.iREN !== 1'b1) begin
        n_errors++;
        $display("FAIL fetch_wait: got pc_en=%b iREN=%b want 0 1", bus.pc_en, bus.iREN);
      end
      @(posedge clk); #1;
    end
    bus.dhit = 1'b0;
    n_checks++;
    if (bus.retired !== model_ret || bus.dREN !== 1'b0) begin
      n_errors++;
      $display("FAIL fetch_wait_state: got retired=%0d dREN=%b want %0d 0", bus.retired, bus.dREN, model_ret);
    end
  endtask

  task automatic test_alu(input int n);
    for (int k = 0; k < n; k++) begin
      bus.ihit = 1'b1;
      model_ret++;
      exp_q.push_back(model_ret);
      #1;
      n_checks++;
      if (bus.pc_en !== 1'b1) begin
        n_errors++;
        $display("FAIL alu_pc_en: got %b want 1", bus.pc_en);
      end
      @(posedge clk); #1;
      pop_retired("alu_retired");
      n_checks++;
      if ({bus.iREN, bus.dREN, bus.dWEN} !== 3'b100) begin
        n_errors++;
        $display("FAIL alu_enables: got %b want 100", {bus.iREN, bus.dREN, bus.dWEN});
      end
    end
    bus.ihit = 1'b0;
  endtask

  task automatic test_data_access(input bit rd, input bit wr, input int delay, input string name);
    logic [2:0] exp_en;
    exp_en = {1'b0, rd && !wr, wr};
    bus.ihit = 1'b1; bus.dren_req = rd; bus.dwen_req = wr;
    #1;
    n_checks++;
    if (bus.pc_en !== 1'b0) begin
      n_errors++;
      $display("FAIL %s_issue_pc_en: got %b want 0", name, bus.pc_en);
    end
    @(posedge clk); #1;
    for (int k = 1; k <= delay; k++) begin
      n_checks++;
      if ({bus.iREN, bus.dREN, bus.dWEN} !== exp_en) begin
        n_errors++;
        $display("FAIL %s_hold: cycle %0d got %b want %b", name, k, {bus.iREN, bus.dREN, bus.dWEN}, exp_en);
      end
      bus.ihit = (k == 1);
      bus.dhit = (k == delay);
      if (k == delay) begin
        model_ret++;
        exp_q.push_back(model_ret);
      end
      #1;
      n_checks++;
      if (bus.pc_en !== (k == delay)) begin
        n_errors++;
        $display("FAIL %s_pc_en: cycle %0d got %b want %b", name, k, bus.pc_en, (k == delay));
      end
      @(posedge clk); #1;
    end
    clear_inputs();
    n_checks++;
    if ({bus.iREN, bus.dREN, bus.dWEN, bus.err} !== 4'b1000) begin
      n_errors++;
      $display("FAIL %s_done: got ien/drn/dwn/err=%b want 1000", name, {bus.iREN, bus.dREN, bus.dWEN, bus.err});
    end
    pop_retired({name, "_retired"});
  endtask

  task automatic test_halt();
    bus.ihit = 1'b1; bus.mem_halt = 1'b1; bus.dwen_req = 1'b1;
    #1;
    n_checks++;
    if (bus.pc_en !== 1'b0) begin
      n_errors++;
      $display("FAIL halt_pc_en: got %b want 0", bus.pc_en);
    end
    @(posedge clk); #1;
    bus.mem_halt = 1'b0; bus.dwen_req = 1'b0; bus.dhit = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if ({bus.halt, bus.iREN, bus.dREN, bus.dWEN, bus.pc_en} !== 5'b10000 || bus.retired !== model_ret) begin
        n_errors++;
        $display("FAIL halt_hold: got hlt/ien/drn/dwn/pc=%b retired=%0d want 10000 retired=%0d",
                 {bus.halt, bus.iREN, bus.dREN, bus.dWEN, bus.pc_en}, bus.retired, model_ret);
      end
      @(posedge clk); #1;
    end
    clear_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_ret = 0;
    n_checks++;
    if ({bus.iREN, bus.dREN, bus.dWEN, bus.halt, bus.err} !== 5'b10000 || bus.retired !== 32'd0) begin
      n_errors++;
      $display("FAIL halt_reset: got ien/drn/dwn/hlt/err=%b retired=%0d want 10000 retired=0",
               {bus.iREN, bus.dREN, bus.dWEN, bus.halt, bus.err}, bus.retired);
    end
  endtask

  task automatic test_rst_mid_data();
    bus.ihit = 1'b1; bus.dwen_req = 1'b1;
    @(posedge clk); #1;
    bus.ihit = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (bus.dWEN !== 1'b1) begin
      n_errors++;
      $display("FAIL rst_mid_pre: got dWEN=%b want 1", bus.dWEN);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_inputs();
    model_ret = 0;
    n_checks++;
    if ({bus.iREN, bus.dWEN, bus.dREN} !== 3'b100 || bus.retired !== 32'd0) begin
      n_errors++;
      $display("FAIL rst_mid_data: got ien/dwn/drn=%b retired=%0d want 100 retired=0",
               {bus.iREN, bus.dWEN, bus.dREN}, bus.retired);
    end
  endtask

`ifdef REQUNIT_TIMEOUT_EN
  task automatic test_timeout();
    bus.ihit = 1'b1; bus.dwen_req = 1'b1;
    @(posedge clk); #1;
    bus.ihit = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      n_checks++;
      if (bus.err !== 1'b0 || bus.halt !== 1'b0 || bus.dWEN !== 1'b1) begin
        n_errors++;
        $display("FAIL timeout_early: cycle %0d got err/halt/dWEN=%b%b%b want 001", k, bus.err, bus.halt, bus.dWEN);
      end
      @(posedge clk); #1;
    end
    clear_inputs();
    n_checks++;
    if ({bus.err, bus.halt, bus.iREN, bus.dREN, bus.dWEN} !== 5'b11000 || bus.retired !== model_ret) begin
      n_errors++;
      $display("FAIL timeout_fire: got err/hlt/ien/drn/dwn=%b retired=%0d want 11000 retired=%0d",
               {bus.err, bus.halt, bus.iREN, bus.dREN, bus.dWEN}, bus.retired, model_ret);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_ret = 0;
    n_checks++;
    if (bus.err !== 1'b0 || bus.halt !== 1'b0) begin
      n_errors++;
      $display("FAIL timeout_reset: got err=%b halt=%b want 0 0", bus.err, bus.halt);
    end
    test_data_access(1'b0, 1'b1, 5, "timeout_dhit_wins");
  endtask
`else
  task automatic test_no_timeout();
    test_data_access(1'b0, 1'b1, 9, "long_store");
    n_checks++;
    if (bus.err !== 1'b0 || bus.halt !== 1'b0) begin
      n_errors++;
      $display("FAIL no_timeout: got err=%b halt=%b want 0 0", bus.err, bus.halt);
    end
  endtask
`endif

  initial begin
    n_checks = 0;
    n_errors = 0;
    model_ret = 0;
    clear_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_fetch_wait();
    test_alu(3);
    test_data_access(1'b1, 1'b0, 4, "load");
    test_alu(1);
    test_data_access(1'b1, 1'b1, 2, "both_req");
    test_data_access(1'b0, 1'b1, 1, "store_fast");
    test_data_access(1'b1, 1'b0, 1, "load_fast");
    test_alu(2);
    test_halt();
    test_alu(1);
    test_rst_mid_data();
`ifdef REQUNIT_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_alu(2);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
